// File: rtl/pkt_bus_packer.sv
// Purpose: packs an MSB-first byte stream into BUS_WIDTH_B-byte words with sop/last marking and an inter-packet gap.
// Latency: 1 cycle from the accepting edge of the word-completing byte to bus_valid_o.
// Backpressure: in_ready_o drops for GAP_CYCLES cycles after each last byte; no output backpressure. Optional plen_o/plen_ovf_o under PKT_BUS_PACKER_PLEN_EN.
module pkt_bus_packer #(
    parameter int BUS_WIDTH_B = 4,
    parameter int BYTE_WIDTH  = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                                 CLK,
    input  logic                                 reset,
    input  logic [BYTE_WIDTH-1:0]                in_byte_i,
    input  logic                                 in_valid_i,
    input  logic                                 in_last_i,
    output logic                                 in_ready_o,
    output logic [BUS_WIDTH_B*BYTE_WIDTH-1:0]    bus_o,
    output logic                                 bus_valid_o,
    output logic                                 start_of_packet_o,
    output logic                                 last_word_o,
`ifdef PKT_BUS_PACKER_PLEN_EN
    output logic [15:0]                          plen_o,
    output logic                                 plen_ovf_o,
`endif
    output logic [$clog2(BUS_WIDTH_B+1)-1:0]     last_bytes_o
);

    localparam int IW  = $clog2(BUS_WIDTH_B);
    localparam int LBW = $clog2(BUS_WIDTH_B+1);
    localparam int WW  = BUS_WIDTH_B*BYTE_WIDTH;
    localparam int GW  = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES+1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           state_q, state_nxt;
    logic [IW-1:0]    idx_q;
    logic [WW-1:0]    acc_q;
    logic [GW-1:0]    gap_cnt_q;
    logic             sop_pend_q;
    logic             ready_q;

    logic             accept;
    logic             emit;
    logic             ready_nxt;
    logic [WW-1:0]    word_nxt;

    // State register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_nxt;
    end

    // Next-state logic: a last byte ends the packet; GAP is skipped entirely when GAP_CYCLES is 0
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE, S_FILL: begin
                if (accept) begin
                    if (in_last_i) state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    else           state_nxt = S_FILL;
                end
            end
            S_GAP: begin
                if (gap_cnt_q <= GW'(1)) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output/datapath decode: accept/emit strobes, the word being completed, and next ready
    always_comb begin
        accept    = in_valid_i && ready_q;
        emit      = accept && (in_last_i || (idx_q == IW'(BUS_WIDTH_B-1)));
        ready_nxt = (state_nxt != S_GAP);
        word_nxt  = acc_q;
        for (int k = 0; k < BUS_WIDTH_B; k++) begin
            if (idx_q == IW'(k)) word_nxt[(BUS_WIDTH_B-k)*BYTE_WIDTH-1 -: BYTE_WIDTH] = in_byte_i;
        end
    end

    assign in_ready_o = ready_q;

    // Byte accumulation, registered word outputs and gap countdown
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            acc_q             <= '0;
            idx_q             <= '0;
            gap_cnt_q         <= '0;
            sop_pend_q        <= 1'b1;
            ready_q           <= 1'b1;
            bus_o             <= '0;
            bus_valid_o       <= 1'b0;
            start_of_packet_o <= 1'b0;
            last_word_o       <= 1'b0;
            last_bytes_o      <= '0;
        end else begin
            ready_q           <= ready_nxt;
            bus_valid_o       <= emit;
            start_of_packet_o <= emit && sop_pend_q;
            last_word_o       <= emit && in_last_i;
            last_bytes_o      <= (emit && in_last_i) ? (LBW'(idx_q) + LBW'(1)) : '0;
            if (emit) bus_o <= word_nxt;

            // Accumulator is cleared on emit so unfilled lanes of a short last word read as zero
            if (accept) begin
                if (emit) begin
                    acc_q <= '0;
                    idx_q <= '0;
                end else begin
                    acc_q <= word_nxt;
                    idx_q <= idx_q + IW'(1);
                end
            end

            if (accept && in_last_i) sop_pend_q <= 1'b1;
            else if (emit)           sop_pend_q <= 1'b0;

            if (accept && in_last_i)                    gap_cnt_q <= GW'(GAP_CYCLES);
            else if (state_q == S_GAP && gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - GW'(1);
        end
    end

`ifdef PKT_BUS_PACKER_PLEN_EN
    logic [15:0] plen_cnt_q;
    logic        plen_sat_q;
    logic [15:0] plen_inc;
    logic        plen_clamp;

    // Saturating length increment for the byte being accepted
    always_comb begin
        plen_clamp = (plen_cnt_q == 16'hFFFF);
        plen_inc   = plen_clamp ? 16'hFFFF : (plen_cnt_q + 16'd1);
    end

    // Packet length counter; reported and cleared on the last byte
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            plen_cnt_q <= '0;
            plen_sat_q <= 1'b0;
            plen_o     <= '0;
            plen_ovf_o <= 1'b0;
        end else begin
            plen_o     <= '0;
            plen_ovf_o <= 1'b0;
            if (accept) begin
                if (in_last_i) begin
                    plen_o     <= plen_inc;
                    plen_ovf_o <= plen_sat_q || plen_clamp;
                    plen_cnt_q <= '0;
                    plen_sat_q <= 1'b0;
                end else begin
                    plen_cnt_q <= plen_inc;
                    plen_sat_q <= plen_sat_q || plen_clamp;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_pkt_bus_packer.sv
// Purpose: directed self-checking bench for pkt_bus_packer with default parameters (4-byte words, gap of 2).
// Latency: expects each word on the negedge following the accepting edge of its completing byte.
// Backpressure: waits (bounded) on in_ready_o before each byte and measures the gap length.
module tb_pkt_bus_packer;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_byte_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_last_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] bus_o;
    logic        bus_valid_o;
    logic        start_of_packet_o;
    logic        last_word_o;
    logic [2:0]  last_bytes_o;
`ifdef PKT_BUS_PACKER_PLEN_EN
    logic [15:0] plen_o;
    logic        plen_ovf_o;
`endif

    int    n_cmp = 0;
    int    n_err = 0;
    int    last_waits = 0;
    string cur_test = "reset";

    always #5 CLK = ~CLK;

    pkt_bus_packer #(
        .BUS_WIDTH_B (4),
        .BYTE_WIDTH  (8),
        .GAP_CYCLES  (2)
    ) dut (
        .CLK               (CLK),
        .reset             (reset),
        .in_byte_i         (in_byte_i),
        .in_valid_i        (in_valid_i),
        .in_last_i         (in_last_i),
        .in_ready_o        (in_ready_o),
        .bus_o             (bus_o),
        .bus_valid_o       (bus_valid_o),
        .start_of_packet_o (start_of_packet_o),
        .last_word_o       (last_word_o),
`ifdef PKT_BUS_PACKER_PLEN_EN
        .plen_o            (plen_o),
        .plen_ovf_o        (plen_ovf_o),
`endif
        .last_bytes_o      (last_bytes_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0h expected %0h", cur_test, tag, obs, exp);
        end
    endtask

    // Offer one byte (waiting for ready), then check the outputs one cycle after acceptance
    task automatic drive(input logic [7:0] b, input logic lst, input logic ew,
                         input logic [31:0] w, input logic es, input logic el,
                         input logic [2:0] elb, input logic [15:0] epl);
        last_waits = 0;
        while (!in_ready_o && last_waits < 20) begin
            @(negedge CLK);
            last_waits++;
        end
        if (!in_ready_o) chk("ready_timeout", 64'd0, 64'd1);
        in_byte_i  = b;
        in_last_i  = lst;
        in_valid_i = 1'b1;
        @(negedge CLK);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        chk("vld", bus_valid_o, ew);
        if (ew) begin
            chk("bus", bus_o, w);
            chk("sop", start_of_packet_o, es);
            chk("last", last_word_o, el);
            chk("lbytes", last_bytes_o, elb);
`ifdef PKT_BUS_PACKER_PLEN_EN
            chk("plen", plen_o, epl);
            chk("plen_ovf", plen_ovf_o, 1'b0);
`else
            if (epl == 16'hFFFF) chk("plen_arg", 64'd0, 64'd1);
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            chk("idle_vld", bus_valid_o, 1'b0);
        end
    endtask

    initial begin
        // Reset state
        @(negedge CLK);
        #1;
        chk("rst_bus", bus_o, 32'h0);
        chk("rst_vld", bus_valid_o, 1'b0);
        chk("rst_sop", start_of_packet_o, 1'b0);
        chk("rst_last", last_word_o, 1'b0);
        chk("rst_lb", last_bytes_o, 3'd0);
        chk("rst_rdy", in_ready_o, 1'b1);
        @(negedge CLK);
        reset = 1'b0;

        // 8 bytes back-to-back -> two full words
        cur_test = "pkt8";
        drive(8'h01, 0, 0, 32'h0, 0, 0, 0, 0);
        drive(8'h02, 0, 0, 32'h0, 0, 0, 0, 0);
        drive(8'h03, 0, 0, 32'h0, 0, 0, 0, 0);
        drive(8'h04, 0, 1, 32'h01020304, 1, 0, 0, 0);
        drive(8'h05, 0, 0, 32'h0, 0, 0, 0, 0);
        drive(8'h06, 0, 0, 32'h0, 0, 0, 0, 0);
        drive(8'h07, 0, 0, 32'h0, 0, 0, 0, 0);
        drive(8'h08, 1, 1, 32'h05060708, 0, 1, 3'd4, 16'd8);

        // 5 bytes -> full word then zero-padded 1-byte word
        cur_test = "pkt5";
        drive(8'h11, 0, 0, 32'h0, 0, 0, 0, 0);
        chk("pkt5_waits", last_waits, 2);
        drive(8'h12, 0, 0, 32'h0, 0, 0, 0, 0);
        drive(8'h13, 0, 0, 32'h0, 0, 0, 0, 0);
        drive(8'h14, 0, 1, 32'h11121314, 1, 0, 0, 0);
        drive(8'h15, 1, 1, 32'h15000000, 0, 1, 3'd1, 16'd5);

        // 1-byte packet: sop and last together
        cur_test = "pkt1";
        drive(8'hAA, 1, 1, 32'hAA000000, 1, 1, 3'd1, 16'd1);

        // 6 bytes with 3 idle cycles between bytes
        cur_test = "stall6";
        drive(8'h31, 0, 0, 32'h0, 0, 0, 0, 0); idle(3);
        drive(8'h32, 0, 0, 32'h0, 0, 0, 0, 0); idle(3);
        drive(8'h33, 0, 0, 32'h0, 0, 0, 0, 0); idle(3);
        drive(8'h34, 0, 1, 32'h31323334, 1, 0, 0, 0); idle(3);
        chk("hold_bus", bus_o, 32'h31323334);
        drive(8'h35, 0, 0, 32'h0, 0, 0, 0, 0); idle(3);
        drive(8'h36, 1, 1, 32'h35360000, 0, 1, 3'd2, 16'd6);

        // Two packets back-to-back: ready low exactly 2 cycles, second packet has sop
        cur_test = "gap";
        drive(8'h41, 0, 0, 32'h0, 0, 0, 0, 0);
        drive(8'h42, 1, 1, 32'h41420000, 1, 1, 3'd2, 16'd2);
        chk("rdy_low", in_ready_o, 1'b0);
        drive(8'h51, 0, 0, 32'h0, 0, 0, 0, 0);
        chk("gap_waits", last_waits, 2);
        drive(8'h52, 0, 0, 32'h0, 0, 0, 0, 0);
        drive(8'h53, 1, 1, 32'h51525300, 1, 1, 3'd3, 16'd3);

        // Reset mid-packet discards partial state
        cur_test = "midrst";
        drive(8'h61, 0, 0, 32'h0, 0, 0, 0, 0);
        drive(8'h62, 0, 0, 32'h0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("bus0", bus_o, 32'h0);
        chk("vld0", bus_valid_o, 1'b0);
        chk("sop0", start_of_packet_o, 1'b0);
        chk("last0", last_word_o, 1'b0);
        chk("lb0", last_bytes_o, 3'd0);
        chk("rdy1", in_ready_o, 1'b1);
        @(negedge CLK);
        reset = 1'b0;
        drive(8'h21, 0, 0, 32'h0, 0, 0, 0, 0);
        chk("post_rst_waits", last_waits, 0);
        drive(8'h22, 0, 0, 32'h0, 0, 0, 0, 0);
        drive(8'h23, 0, 0, 32'h0, 0, 0, 0, 0);
        drive(8'h24, 1, 1, 32'h21222324, 1, 1, 3'd4, 16'd4);
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
